text_writer: RTL
================

# text_writer

Character-buffer writer for the 60x17 text console. It accepts a byte stream over a valid/ready handshake and interprets printable bytes and a small set of control codes. It drives the write port (port A) of the 64x32 color character buffer with {attribute, character} words, keeping the display scanout on port B fed with text. It owns the cursor, line wrap, row wrap and the clear operations, so upstream logic (UART, CPU, test pattern) only supplies bytes and colors.

## Interface
- COLS, 60, visible columns; cursor column range 0..COLS-1
- ROWS, 17, visible rows; cursor row range 0..ROWS-1
- BLANK, 8'h20, character code written by clear operations
- i_clk  in  1  pixel clock (LCD_CLK domain, same clock as the buffer ports)
- i_rst_n  in  1  reset; synchronous and active-low
- i_valid  in  1  byte available
- i_data  in  8  byte: character code or control code
- i_attr  in  8  color attribute {irgb back, irgb fore}; sampled with i_data
- o_ready  out  1  block can accept a byte this cycle
- o_ada  out  11  buffer write address {row[4:0], col[5:0]}
- o_din  out  16  buffer write data {attr, char}
- o_cea  out  1  buffer write enable (one word per cycle when high)
- o_col  out  6  current cursor column
- o_row  out  5  current cursor row

## Operation
- Transfer occurs on a rising edge with i_valid & o_ready high; i_data/i_attr are captured at that edge.
- States: IDLE (ready), CLR_ROW, CLR_ALL. All outputs are registered.
- Byte decode in IDLE:
  - 0x0D (CR): col <= 0; no write.
  - 0x0A (LF): col <= 0; row advance; enter CLR_ROW.
  - 0x08 (BS): col <= col-1 if col>0, else unchanged; no write.
  - 0x0C (FF): enter CLR_ALL; cursor <= (0,0).
  - Any other value: glyph write of {i_attr, i_data} at {row, col}; col <= col+1. If col was COLS-1: col <= 0, row advance, enter CLR_ROW.
- Row advance: row <= (row==ROWS-1) ? 0 : row+1. There is no scroll; the destination row is always blanked.
- CLR_ROW: writes {captured attr, BLANK} to addresses {row,6'd0}..{row,6'd63}, 64 words, ascending, then returns to IDLE. The hidden columns 60..63 are cleared as well.
- CLR_ALL: writes {captured attr, BLANK} to addresses 0..2047, ascending, then returns to IDLE.
- Reset does not touch buffer contents. A reset asserted during CLR_ROW or CLR_ALL aborts the clear immediately, leaving the buffer partially cleared.
- Hidden rows 17..31 are written only by CLR_ALL.

## Timing
- Reset values: o_ready=0, o_cea=0, o_ada=0, o_din=0, o_col=0, o_row=0, state IDLE. o_ready rises one cycle after the first edge with i_rst_n=1.
- A byte accepted at edge E produces its write (o_cea=1 with o_ada/o_din valid) in the cycle after E. o_col/o_row show the updated cursor in that same cycle.
- Printable without line wrap: o_ready stays high. Back-to-back bytes produce one write per cycle, at full throughput.
- Printable with line wrap (accepted at edge E): glyph write in cycle E+1, clear writes in cycles E+2..E+65. o_ready is low in cycles E+1..E+65 and high in E+66.
- LF at edge E: clear writes in E+1..E+64, o_ready low in E+1..E+64 and high in E+65.
- FF at edge E: clear writes in E+1..E+2048, o_ready low in E+1..E+2048 and high in E+2049.
- CR and BS: no write; o_ready stays high.
- o_cea is low in every cycle without a write. o_ada/o_din hold their last values when o_cea=0.
- i_valid without o_ready has no effect. Input bytes are never dropped or duplicated.

## Test plan
- Reset, then send 'A' (0x41) with attr 0x1F: one write, o_ada=0, o_din=16'h1F41. Then o_col=1, o_row=0, and o_ready stays 1.
- Send 60 consecutive bytes 0x30 from (0,0) with attr 0x07:
  - 60 writes to addresses 0..59 in 60 consecutive cycles.
  - 64 clear writes of 16'h0720 to addresses 64..127.
  - o_ready is low for 65 cycles; cursor ends at (1,0).
- Cursor at row 16: send LF with attr 0x70. 64 writes of 16'h7020 to addresses 0..63; cursor ends at (0,0); o_ready is low for exactly 64 cycles.
- Send FF with attr 0x00: 2048 writes of 16'h0020 to addresses 0..2047 in ascending order. o_ready returns to 1 at cycle 2049; cursor is (0,0).
- Cursor at (3,5): send CR, then BS, then BS at col 0. No writes occur and o_ready stays 1; cursor goes (3,0), then stays at (3,0).
- Start FF, then assert i_rst_n=0 at clear address 100 for one cycle. o_cea is 0 on the following cycle and all outputs are at reset values. After release, 'B' writes to address 0.

Source files
------------

// File: rtl/text_writer.sv
// Byte-stream writer for the 60x17 text console: decodes glyphs and control codes,
// tracks the cursor and drives the write port of the 64x32 {attr, char} buffer.
module text_writer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    input  logic [7:0]  i_attr,
    output logic        o_ready,
    output logic [10:0] o_ada,
    output logic [15:0] o_din,
    output logic        o_cea,
    output logic [5:0]  o_col,
    output logic [4:0]  o_row,
    output logic [1:0]  o_state
);

    localparam int         COLS     = 60;
    localparam int         ROWS     = 17;
    localparam logic [7:0] BLANK    = 8'h20;
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_FF = 8'h0C;
    localparam logic [7:0] CODE_CR = 8'h0D;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLR_ROW = 2'd1,
        S_CLR_ALL = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_col;
    logic [4:0]  r_row;
    logic [7:0]  r_attr;
    logic [10:0] r_cnt;
    logic        r_ready;
    logic        r_cea;
    logic [10:0] r_ada;
    logic [15:0] r_din;

    state_t      w_state;
    logic [5:0]  w_col;
    logic [4:0]  w_row;
    logic [7:0]  w_attr;
    logic [10:0] w_cnt;
    logic        w_ready;
    logic        w_cea;
    logic [10:0] w_ada;
    logic [15:0] w_din;
    logic [4:0]  w_row_adv;
    logic        w_accept;

    // Handshake: a byte transfers on a rising edge where i_valid and o_ready are both high;
    // o_ready is registered and only ever high in IDLE, so a transfer never lands mid-clear.
    assign w_accept  = i_valid & r_ready;
    assign w_row_adv = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;

    always_comb begin
        w_state = r_state;
        w_col   = r_col;
        w_row   = r_row;
        w_attr  = r_attr;
        w_cnt   = r_cnt;
        w_ready = r_ready;
        w_cea   = 1'b0;
        w_ada   = r_ada;
        w_din   = r_din;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    case (i_data)
                        CODE_CR: w_col = 6'd0;
                        CODE_BS: begin
                            if (r_col != 6'd0) w_col = r_col - 6'd1;
                        end
                        // LF and FF issue their first clear word at the accept edge itself.
                        CODE_LF: begin
                            w_col   = 6'd0;
                            w_row   = w_row_adv;
                            w_attr  = i_attr;
                            w_cea   = 1'b1;
                            w_ada   = {w_row_adv, 6'd0};
                            w_din   = {i_attr, BLANK};
                            w_cnt   = 11'd1;
                            w_ready = 1'b0;
                            w_state = S_CLR_ROW;
                        end
                        CODE_FF: begin
                            w_col   = 6'd0;
                            w_row   = 5'd0;
                            w_attr  = i_attr;
                            w_cea   = 1'b1;
                            w_ada   = 11'd0;
                            w_din   = {i_attr, BLANK};
                            w_cnt   = 11'd1;
                            w_ready = 1'b0;
                            w_state = S_CLR_ALL;
                        end
                        default: begin
                            w_cea = 1'b1;
                            w_ada = {r_row, r_col};
                            w_din = {i_attr, i_data};
                            if (r_col == LAST_COL) begin
                                w_col   = 6'd0;
                                w_row   = w_row_adv;
                                w_attr  = i_attr;
                                w_cnt   = 11'd0;
                                w_ready = 1'b0;
                                w_state = S_CLR_ROW;
                            end else begin
                                w_col = r_col + 6'd1;
                            end
                        end
                    endcase
                end
            end
            S_CLR_ROW: begin
                w_ready = 1'b0;
                w_cea   = 1'b1;
                w_ada   = {r_row, r_cnt[5:0]};
                w_din   = {r_attr, BLANK};
                w_cnt   = r_cnt + 11'd1;
                if (r_cnt[5:0] == 6'd63) w_state = S_IDLE;
            end
            S_CLR_ALL: begin
                w_ready = 1'b0;
                w_cea   = 1'b1;
                w_ada   = r_cnt;
                w_din   = {r_attr, BLANK};
                w_cnt   = r_cnt + 11'd1;
                if (r_cnt == 11'd2047) w_state = S_IDLE;
            end
            default: begin
                w_ready = 1'b0;
                w_state = S_IDLE;
            end
        endcase
    end

    // Returning to IDLE leaves o_ready low for one more cycle before it re-arms.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_col   <= 6'd0;
            r_row   <= 5'd0;
            r_attr  <= 8'd0;
            r_cnt   <= 11'd0;
            r_ready <= 1'b0;
            r_cea   <= 1'b0;
            r_ada   <= 11'd0;
            r_din   <= 16'd0;
        end else begin
            r_state <= w_state;
            r_col   <= w_col;
            r_row   <= w_row;
            r_attr  <= w_attr;
            r_cnt   <= w_cnt;
            r_ready <= w_ready;
            r_cea   <= w_cea;
            r_ada   <= w_ada;
            r_din   <= w_din;
        end
    end

    assign o_ready = r_ready;
    assign o_cea   = r_cea;
    assign o_ada   = r_ada;
    assign o_din   = r_din;
    assign o_col   = r_col;
    assign o_row   = r_row;
    assign o_state = r_state;

endmodule
